// File: rtl/acc_mem_pkg.sv
// Shared types and constants for the accumulator/memory transfer sequencer.
package acc_mem_pkg;

   localparam int DEFAULT_WIDTH      = 8;
   localparam int DEFAULT_ADDR_WIDTH = 8;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/acc_mem_watchdog.sv
// Request watchdog: down-counter loaded on clear, counting while enabled.
// Only instantiated when ACC_MEM_TIMEOUT_EN is defined.
module acc_mem_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count_reg;

   // Loaded with TIMEOUT_CYCLES-1 so that expiry lands in the last allowed cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= CW'(TIMEOUT_CYCLES - 1);
      end else if (enable && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign expired = enable && (count_reg == '0);

endmodule

// File: rtl/acc_mem_transfer_unit.sv
// Sequencer moving words between the accumulator and data memory over req/ack.
// Define ACC_MEM_TIMEOUT_EN to bound the wait for mem_ack and report err.
module acc_mem_transfer_unit
   import acc_mem_pkg::*;
#(
   parameter int WIDTH          = DEFAULT_WIDTH,
   parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  op,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      acc_q,
   output logic [WIDTH-1:0]      acc_d,
   output logic                  acc_ld_str,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   input  logic                  mem_ack,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t                state_reg, state_next;
   logic                  op_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [WIDTH-1:0]      wdata_reg;
   logic [WIDTH-1:0]      rdata_reg;
   logic                  start_accept;
   logic                  timeout;

   assign start_accept = (state_reg == IDLE) && start;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         op_reg    <= OP_LOAD;
         addr_reg  <= '0;
         wdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (start_accept) begin
            op_reg   <= op;
            addr_reg <= addr;
            // Store data is frozen at the start edge; later acc_q changes are irrelevant.
            if (op == OP_STORE) begin
               wdata_reg <= acc_q;
            end
         end
         if ((state_reg == REQ) && mem_ack && (op_reg == OP_LOAD)) begin
            rdata_reg <= mem_rdata;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = REQ;
         REQ: begin
            if (mem_ack) begin
               state_next = (op_reg == OP_STORE) ? DONE : WB;
            end else if (timeout) begin
               state_next = DONE;
            end
         end
         WB:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy       = (state_reg != IDLE);
   assign mem_req    = (state_reg == REQ);
   assign mem_we     = mem_req && (op_reg == OP_STORE);
   assign mem_addr   = addr_reg;
   assign mem_wdata  = wdata_reg;
   assign acc_ld_str = (state_reg == WB);
   assign acc_d      = rdata_reg;
   assign done       = (state_reg == DONE);

`ifdef ACC_MEM_TIMEOUT_EN
   logic expired;
   logic err_reg;

   // Expiry is suppressed by a same-cycle ack, so an ack always wins.
   acc_mem_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (start_accept),
      .enable  ((state_reg == REQ) && !mem_ack),
      .expired (expired)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else if (state_reg == REQ) begin
         err_reg <= expired;
      end
   end

   assign timeout = expired;
   assign err     = (state_reg == DONE) && err_reg;
`else
   assign timeout = 1'b0;
   assign err     = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_acc_mem_transfer_unit.sv
// Randomized scoreboard bench for acc_mem_transfer_unit with a behavioural memory and accumulator.
module tb_acc_mem_transfer_unit;
   import acc_mem_pkg::*;

   localparam int T = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       op = 1'b0;
   logic [7:0] addr = '0;
   logic [7:0] acc_q = '0;
   logic [7:0] mem_rdata = '0;
   logic       mem_ack = 1'b0;
   logic [7:0] acc_d, mem_addr, mem_wdata;
   logic       acc_ld_str, mem_req, mem_we, busy, done, err;

   acc_mem_transfer_unit #(
      .WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(T)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .addr(addr),
      .acc_q(acc_q), .acc_d(acc_d), .acc_ld_str(acc_ld_str),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       op;
      logic [7:0] addr;
      logic [7:0] data;
      logic       err;
      logic [7:0] acc;
      int         done_cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         delay_q[$];
   logic [7:0] mem_arr[256];
   logic [7:0] ref_mem[256];
   logic [7:0] ref_acc = '0;
   logic [7:0] acc_model = '0;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         issued = 0;
   int         done_seen = 0;

   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) if (acc_ld_str) acc_model <= acc_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Memory responder: acks after the per-request delay chosen by the stimulus.
   initial begin
      int  k = 0;
      int  d = 0;
      bit  active = 0;
      forever begin
         @(negedge clock);
         mem_ack = 1'b0;
         if (!mem_req || reset) begin
            active = 0;
            mem_rdata = 8'($urandom);
            if (!reset && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
         end else begin
            if (!active) begin
               active = 1;
               k = 1;
               d = (delay_q.size() > 0) ? delay_q.pop_front() : 1000;
            end else begin
               k++;
            end
            if (k == d) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_arr[mem_addr];
               if (mem_we) mem_arr[mem_addr] = mem_wdata;
            end else begin
               mem_rdata = 8'($urandom);
            end
         end
      end
   end

   // Monitor: compares port activity against the head of the expectation queue.
   initial begin
      bit   saw_ld = 0;
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (reset) continue;
         if (mem_req && exp_q.size() > 0) begin
            e = exp_q[0];
            check("req_port", {15'd0, mem_we, mem_addr, (e.op == OP_STORE) ? mem_wdata : 8'd0},
                  {15'd0, e.op, e.addr, (e.op == OP_STORE) ? e.data : 8'd0});
         end
         if (acc_ld_str) begin
            saw_ld = 1;
            if (exp_q.size() == 0) begin
               check("ld_unexpected", 32'(acc_ld_str), 32'd0);
            end else begin
               e = exp_q[0];
               check("ld_allowed", {e.op, e.err}, {OP_LOAD, 1'b0});
               check("ld_data", 32'(acc_d), 32'(e.data));
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               check("done_unexpected", 32'(done), 32'd0);
            end else begin
               e = exp_q.pop_front();
               done_seen++;
               check("done_err", 32'(err), 32'(e.err));
               check("done_ld_pulse", 32'(saw_ld), 32'((e.op == OP_LOAD) && !e.err));
               check("done_cycle", 32'(cyc), 32'(e.done_cyc));
               check("acc_value", 32'(acc_model), 32'(e.acc));
            end
            saw_ld = 0;
         end
      end
   end

   // Issue one transfer from a negedge; the expected outcome comes from the memory model.
   task automatic issue(input logic o, input logic [7:0] a, input logic [7:0] data,
                        input int d, input logic [7:0] acc_after);
      exp_t e;
      int   waitc = 0;
      while (busy && waitc < 200) begin
         @(negedge clock);
         waitc++;
      end
      if (busy) begin
         check("idle_wait", 32'(busy), 32'd0);
         return;
      end
      e.op   = o;
      e.addr = a;
      e.err  = 1'b0;
`ifdef ACC_MEM_TIMEOUT_EN
      e.err  = (d > T);
`endif
      if (o == OP_STORE) begin
         e.data = data;
         if (!e.err) ref_mem[a] = data;
      end else begin
         e.data = ref_mem[a];
         if (!e.err) ref_acc = ref_mem[a];
      end
      e.acc      = ref_acc;
      e.done_cyc = cyc + 1 + (e.err ? T : d + ((o == OP_LOAD) ? 1 : 0));
      exp_q.push_back(e);
      delay_q.push_back(d);
      issued++;
      start = 1'b1;
      op    = o;
      addr  = a;
      acc_q = data;
      @(negedge clock);
      start = 1'b0;
      acc_q = acc_after;
      op    = 1'($urandom);
      addr  = 8'($urandom);
      if ($urandom_range(0, 2) == 0 && busy) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
   endtask

   initial begin
      int waitc = 0;
      int bad = 0;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 8'($urandom);
         ref_mem[i] = mem_arr[i];
      end
      mem_arr[8'h10] = 8'hA5;
      ref_mem[8'h10] = 8'hA5;

      repeat (2) @(negedge clock);
      check("reset_outputs", {2'd0, acc_d, acc_ld_str, mem_req, mem_we, mem_addr, mem_wdata, busy, done, err}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Reset in the middle of a request.
      start = 1'b1; op = OP_LOAD; addr = 8'h33;
      @(negedge clock);
      start = 1'b0;
      check("midreq_req", 32'(mem_req), 32'd1);
      #1 reset = 1'b1;
      #1 check("midreq_reset", {mem_req, busy, done, acc_ld_str}, 4'b0000);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      issue(OP_LOAD,  8'h10, 8'h5C, 3, 8'h5C);
      issue(OP_STORE, 8'h20, 8'h03, 1, 8'hFF);
      issue(OP_LOAD,  8'h20, 8'h00, 2, 8'h00);
      issue(OP_STORE, 8'h21, 8'hC7, 5, 8'h11);
`ifdef ACC_MEM_TIMEOUT_EN
      issue(OP_LOAD,  8'h10, 8'h00, 5, 8'h00);
      issue(OP_STORE, 8'h40, 8'h99, 4, 8'h00);
      issue(OP_STORE, 8'h41, 8'h77, 6, 8'h00);
      issue(OP_LOAD,  8'h41, 8'h00, 1, 8'h00);
`endif

      for (int n = 0; n < 40; n++) begin
         int d;
`ifdef ACC_MEM_TIMEOUT_EN
         d = $urandom_range(1, 6);
`else
         d = $urandom_range(1, 5);
`endif
         issue(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), d, 8'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      while (exp_q.size() > 0 && waitc < 300) begin
         @(negedge clock);
         waitc++;
      end
      repeat (3) @(negedge clock);
      check("all_done", 32'(done_seen), 32'(issued));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 256; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
      check("memory_image", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/acc_mem_transfer_unit.md
Name: acc_mem_transfer_unit

Overview:
Sequencer that moves data between the accumulator (an n-bit load/store register) and data memory over a req/ack handshake.
- LOAD: reads memory and drives the accumulator's d/ld_str pins to capture the word.
- STORE: takes the accumulator's q and writes it to memory.
- Sits between the processor control unit (start/op/addr) and the memory port.

Parameters:
- WIDTH, 8, data width; matches accumulator width.
- ADDR_WIDTH, 8, memory address width.
- TIMEOUT_CYCLES, 16, maximum cycles waiting for mem_ack; used only with the optional feature.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request from control unit; sampled only in IDLE.
- op  input  1  0 = LOAD (mem->acc), 1 = STORE (acc->mem).
- addr  input  ADDR_WIDTH  memory address, sampled with start.
- acc_q  input  WIDTH  accumulator output.
- acc_d  output  WIDTH  data to accumulator.
- acc_ld_str  output  1  1 = accumulator loads acc_d on the next edge.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  WIDTH  write data.
- mem_rdata  input  WIDTH  read data; valid when mem_ack = 1.
- mem_ack  input  1  memory completion.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle timeout pulse, coincident with done.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; all outputs 0, including acc_d, mem_addr and mem_wdata. A reset mid-transfer drops mem_req at once, and no accumulator write occurs.
- States:
  - IDLE: on start = 1, latch op, addr, and (if STORE) acc_q; go to REQ.
  - REQ: mem_req = 1; mem_we = op; mem_addr and mem_wdata are the latched values and stay stable until ack. If mem_ack = 1 in a cycle where mem_req = 1:
    - LOAD: latch mem_rdata, go to WB.
    - STORE: go to DONE.
    - Otherwise stay in REQ.
  - WB: acc_ld_str = 1 and acc_d = latched read data for exactly one cycle; go to DONE.
  - DONE: done = 1 for one cycle; go to IDLE.
- Latency from start (edge N) to done:
  - STORE with ack on the first REQ cycle: mem_req high in cycle N+1, done high in N+2.
  - LOAD, same ack timing: acc_ld_str high in N+2, done high in N+3, accumulator updated at the end of N+3.
- mem_req deasserts in the cycle after ack is seen. The memory must not hold ack across two requests.
- mem_ack while mem_req = 0 is ignored.
- start while busy is ignored; it is neither queued nor flagged.
- acc_ld_str is 0 outside WB. acc_d holds its last value (no glitch-to-zero).
- STORE data is the acc_q value at the start edge, not later values.

Optional Feature:
- Macro: ACC_MEM_TIMEOUT_EN
- Enabled:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: drop mem_req, skip WB, go to DONE with err = 1 alongside done.
  - The accumulator is untouched.
  - An ack arriving in the same cycle as the timeout wins: normal completion, err = 0.
- Disabled: REQ waits indefinitely; err is tied to 0; no counter logic is synthesized.

Decomposition:
- Shared package acc_mem_pkg:
  - State enum: IDLE, REQ, WB, DONE.
  - Op constants: OP_LOAD = 0, OP_STORE = 1.
  - Default WIDTH and ADDR_WIDTH constants.
- One natural sub-module: acc_mem_watchdog. It is a TIMEOUT_CYCLES down-counter with clear/enable/expired, and is instantiated only under ACC_MEM_TIMEOUT_EN.

Test Plan:
- Reset mid-REQ: assert reset while mem_req = 1 -> mem_req, busy and done go to 0 immediately; acc_ld_str never pulses.
- LOAD addr = 8'h10, memory acks after 3 cycles with rdata = 8'hA5 -> mem_we = 0, mem_addr = 8'h10 held stable for 3 cycles, acc_ld_str pulse with acc_d = 8'hA5, done 1 cycle later, accumulator q = 8'hA5.
- STORE addr = 8'h20 with acc_q = 8'h03; change acc_q to 8'hFF after start; ack on the first cycle -> mem_we = 1, mem_wdata = 8'h03, done at N+2, acc_ld_str stays 0.
- start pulsed during busy, plus a spurious mem_ack in IDLE -> no extra transfer; exactly one done pulse.
- ACC_MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> mem_req high for 4 cycles, then done = 1 and err = 1; accumulator unchanged. Ack on the 4th cycle -> err = 0.
